// File: rtl/hex_display_sequencer_if.sv
// Avalon-MM write-master bundle used to drive the six HEX PIO digit registers.
interface hex_display_sequencer_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/hex_display_sequencer.sv
// Converts a 20-bit value to six BCD digits and writes their 7-segment codes to HEX0..HEX5.
// Optional HEX_BLANK_LEADING_EN blanks leading zero digits above digit 0.
//
// state   | meaning
// IDLE    | waiting for value_valid
// CONVERT | 20 double-dabble iterations, one per cycle
// WRITE   | six Avalon writes, digit 0 first
// DONE    | one-cycle done pulse; restarts on a pending value
module hex_display_sequencer (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [19:0]                     value_in,
  input  logic                            value_valid,
  output logic                            busy,
  output logic                            done,
  hex_display_sequencer_if.master         avm
);

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

  localparam logic [19:0] VALUE_MAX = 20'd999999;

  state_t      state, state_nxt;
  logic [19:0] bin_q;
  logic [23:0] bcd_q;
  logic [23:0] bcd_adj;
  logic [4:0]  iter_q;
  logic [2:0]  digit_q;
  logic        pend_valid_q;
  logic [19:0] pend_value_q;
  logic [19:0] value_clamped;
  logic        load;
  logic [19:0] load_value;
  logic [3:0]  digit_nib;
  logic [6:0]  seg_data;

  assign value_clamped = (value_in > VALUE_MAX) ? VALUE_MAX : value_in;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    case (digit_q)
      3'd0:    digit_nib = bcd_q[3:0];
      3'd1:    digit_nib = bcd_q[7:4];
      3'd2:    digit_nib = bcd_q[11:8];
      3'd3:    digit_nib = bcd_q[15:12];
      3'd4:    digit_nib = bcd_q[19:16];
      default: digit_nib = bcd_q[23:20];
    endcase
  end

`ifdef HEX_BLANK_LEADING_EN
  logic upper_zero;
  // a digit is leading when it and every higher digit are zero
  assign upper_zero = ((bcd_q >> {digit_q, 2'b00}) == 24'd0);
  assign seg_data   = (digit_q != 3'd0 && upper_zero) ? 7'h7F : seg7(digit_nib);
`else
  assign seg_data   = seg7(digit_nib);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    busy               = 1'b1;
    done               = 1'b0;
    load               = 1'b0;
    load_value         = value_clamped;
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_address    = 3'd0;
    avm.avm_writedata  = 32'd0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (value_valid) begin
          load      = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (iter_q == 5'd0) state_nxt = WRITE;
      end
      WRITE: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = digit_q;
        avm.avm_writedata  = {25'd0, seg_data};
        if (!avm.avm_waitrequest && digit_q == 3'd5) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // a strobe landing on the DONE cycle is newer than anything pending
        if (value_valid) begin
          load      = 1'b1;
          state_nxt = CONVERT;
        end else if (pend_valid_q) begin
          load       = 1'b1;
          load_value = pend_value_q;
          state_nxt  = CONVERT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q        <= 20'd0;
      bcd_q        <= 24'd0;
      iter_q       <= 5'd0;
      digit_q      <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_value_q <= 20'd0;
    end else begin
      if (load) begin
        bin_q   <= load_value;
        bcd_q   <= 24'd0;
        iter_q  <= 5'd19;
        digit_q <= 3'd0;
      end else if (state == CONVERT) begin
        {bcd_q, bin_q} <= {bcd_adj[22:0], bin_q, 1'b0};
        iter_q         <= iter_q - 5'd1;
      end else if (state == WRITE && !avm.avm_waitrequest) begin
        digit_q <= digit_q + 3'd1;
      end

      if (state == DONE) begin
        pend_valid_q <= 1'b0;
      end else if (value_valid && state != IDLE) begin
        pend_valid_q <= 1'b1;
        pend_value_q <= value_clamped;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer: digit writes, latency, stalls, pending strobes, reset abort.
module tb_hex_display_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] value_in;
  logic        value_valid;
  logic        busy;
  logic        done;

  hex_display_sequencer_if avm ();

  hex_display_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .busy        (busy),
    .done        (done),
    .avm         (avm.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  logic [2:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int done_cnt, done_rel, first_wr_rel;
  int a2_cycles, a2_bad, stall_cnt;
  bit stall_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave model: optional 3-cycle stall on digit 2, then log accepted writes
  always @(negedge clk) begin
    if (stall_en && avm.avm_chipselect && avm.avm_address == 3'd2 && stall_cnt < 3) begin
      avm.avm_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      avm.avm_waitrequest = 1'b0;
    end
    if (avm.avm_chipselect === 1'b1 && avm.avm_write_n === 1'b0) begin
      if (first_wr_rel < 0) first_wr_rel = cyc - start_cyc;
      if (avm.avm_address == 3'd2) begin
        a2_cycles++;
        if (avm.avm_writedata != 32'h24) a2_bad++;
      end
      if (!avm.avm_waitrequest) begin
        wr_addr.push_back(avm.avm_address);
        wr_data.push_back(avm.avm_writedata);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_seg(input int v, input int n);
    int c, p, d;
    c = (v > 999999) ? 999999 : v;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    d = (c / p) % 10;
`ifdef HEX_BLANK_LEADING_EN
    if (n > 0 && c / p == 0) return 32'h7F;
`endif
    case (d)
      0: return 32'h40;
      1: return 32'h79;
      2: return 32'h24;
      3: return 32'h30;
      4: return 32'h19;
      5: return 32'h12;
      6: return 32'h02;
      7: return 32'h78;
      8: return 32'h00;
      default: return 32'h10;
    endcase
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    done_rel = -1;
    first_wr_rel = -1;
    a2_cycles = 0;
    a2_bad = 0;
    stall_cnt = 0;
  endtask

  task automatic pulse(input int v);
    @(negedge clk);
    value_in    = v[19:0];
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic strobe(input int v);
    @(negedge clk);
    value_in    = v[19:0];
    value_valid = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done_cnt >= n), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input int v, input int base);
    check({tag, "_count"}, 32'(wr_addr.size() >= base + 6), 32'd1);
    if (wr_addr.size() >= base + 6) begin
      for (int n = 0; n < 6; n++) begin
        check($sformatf("%s_addr%0d", tag, n), 32'(wr_addr[base+n]), 32'(n));
        check($sformatf("%s_data%0d", tag, n), wr_data[base+n], exp_seg(v, n));
      end
    end
  endtask

  initial begin
    int k;
    int vals[4];
    reset = 1'b1;
    value_valid = 1'b0;
    value_in = 20'd0;
    clear_log();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cs", 32'(avm.avm_chipselect), 32'd0);
    check("rst_wn", 32'(avm.avm_write_n), 32'd1);
    check("rst_addr", 32'(avm.avm_address), 32'd0);
    check("rst_data", avm.avm_writedata, 32'd0);
    reset = 1'b0;

    // 1234 with no stalls: latency and digit order
    clear_log();
    strobe(1234);
    check("busy_accept", 32'(busy), 32'd1);
    wait_done(1, 100);
    check("v1234_first_wr", 32'(first_wr_rel), 32'd21);
    check("v1234_done_cyc", 32'(done_rel), 32'd27);
    check("v1234_nwr", 32'(wr_addr.size()), 32'd6);
    check_seq("v1234", 1234, 0);
`ifndef HEX_BLANK_LEADING_EN
    if (wr_data.size() >= 6) begin
      check("v1234_lit0", wr_data[0], 32'h19);
      check("v1234_lit3", wr_data[3], 32'h79);
      check("v1234_lit5", wr_data[5], 32'h40);
    end
`endif
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cs", 32'(avm.avm_chipselect), 32'd0);

    // clamp, boundary and small values
    vals[0] = 1048575; vals[1] = 999999; vals[2] = 0; vals[3] = 7;
    for (int i = 0; i < 4; i++) begin
      clear_log();
      strobe(vals[i]);
      wait_done(1, 100);
      check($sformatf("v%0d_done_cyc", vals[i]), 32'(done_rel), 32'd27);
      check_seq($sformatf("v%0d", vals[i]), vals[i], 0);
    end

    // waitrequest stall on digit 2
    clear_log();
    stall_en = 1'b1;
    strobe(1234);
    wait_done(1, 100);
    stall_en = 1'b0;
    check("stall_a2_cycles", 32'(a2_cycles), 32'd4);
    check("stall_a2_stable", 32'(a2_bad), 32'd0);
    check("stall_done_cyc", 32'(done_rel), 32'd30);
    check_seq("stall", 1234, 0);

    // two strobes while busy: only the last one runs
    clear_log();
    strobe(1234);
    repeat (3) @(negedge clk);
    pulse(5);
    repeat (4) @(negedge clk);
    pulse(8);
    wait_done(2, 200);
    repeat (40) @(negedge clk);
    check("pend_nwr", 32'(wr_addr.size()), 32'd12);
    check("pend_ndone", 32'(done_cnt), 32'd2);
    check_seq("pend_first", 1234, 0);
    check_seq("pend_last", 8, 6);

    // strobe landing on the DONE cycle
    clear_log();
    strobe(42);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("donestrobe_seen", 32'(done), 32'd1);
    value_in = 20'd9;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_done(2, 100);
    check_seq("donestrobe_a", 42, 0);
    check_seq("donestrobe_b", 9, 6);

    // reset wins over value_valid
    @(negedge clk);
    reset = 1'b1;
    value_valid = 1'b1;
    value_in = 20'd55;
    @(negedge clk);
    reset = 1'b0;
    value_valid = 1'b0;
    check("rstprio_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("rstprio_busy2", 32'(busy), 32'd0);

    // reset during the digit-3 write aborts the sequence
    clear_log();
    strobe(1234);
    k = 0;
    while (!(avm.avm_chipselect === 1'b1 && avm.avm_address == 3'd3) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_a3", 32'(avm.avm_address), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs", 32'(avm.avm_chipselect), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    k = wr_addr.size();
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_more_wr", 32'(wr_addr.size()), 32'(k));
    check("abort_no_done", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
